// File: rtl/uart_sink_if.sv
// ---------------------------------------------------------------------------
// uart_sink_if
// Byte-stream and result bus between a UART receiver/consumer pair and the
// uart_sink accumulator.
//   i_data    [7:0]  received byte, qualified by i_valid
//   i_valid          one-cycle strobe, i_data valid this cycle
//   i_ack            consumer acknowledge of a DONE/ERROR result
//   o_sum     [31:0] running modulo-2^32 sum of accepted bytes
//   o_count   [CW]   number of bytes accepted, CW = $clog2(MESSAGE_LEN+1)
//   o_busy           message in progress
//   o_done           full message received, result pending
//   o_error          inter-byte timeout, result pending
//   o_overrun        sticky: byte arrived while a result was pending
// master: the side that feeds bytes and consumes results.
// slave : the uart_sink itself.
// ---------------------------------------------------------------------------
interface uart_sink_if #(
   parameter int MESSAGE_LEN = 512
) ();
   localparam int CW = $clog2(MESSAGE_LEN + 1);

   logic [7:0]    i_data;
   logic          i_valid;
   logic          i_ack;
   logic [31:0]   o_sum;
   logic [CW-1:0] o_count;
   logic          o_busy;
   logic          o_done;
   logic          o_error;
   logic          o_overrun;

   modport master (
      output i_data, i_valid, i_ack,
      input  o_sum, o_count, o_busy, o_done, o_error, o_overrun
   );

   modport slave (
      input  i_data, i_valid, i_ack,
      output o_sum, o_count, o_busy, o_done, o_error, o_overrun
   );
endinterface

// File: rtl/uart_sink.sv
// ---------------------------------------------------------------------------
// uart_sink
// Accumulates a fixed-length message of bytes from a UART receiver into a
// 32-bit wrapping sum and a byte count, flags completion or an inter-byte
// timeout, and holds the result until the consumer acknowledges it.
//   clk   sole clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   uart_sink_if.slave (byte input, ack, sum/count/status outputs)
// Parameters:
//   MESSAGE_LEN  message length in bytes (1..65535)
//   TIMEOUT      inter-byte idle limit in clk cycles while receiving (>= 2)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no message in progress, sum/count are zero
// ST_RECV  | message in progress, inter-byte timer running
// ST_DONE  | MESSAGE_LEN bytes accepted, result held until i_ack
// ST_ERROR | timer expired mid-message, partial result held until i_ack
// ---------------------------------------------------------------------------
module uart_sink #(
   parameter int MESSAGE_LEN = 512,
   parameter int TIMEOUT     = 100000
) (
   input  logic       clk,
   input  logic       rst,
   uart_sink_if.slave bus
);

   localparam int CW = $clog2(MESSAGE_LEN + 1);
   localparam int TW = $clog2(TIMEOUT);

   localparam logic [CW-1:0] LAST_IDX  = CW'(MESSAGE_LEN - 1);
   localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RECV  = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   sum_q, sum_d;
   logic [CW-1:0] count_q, count_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          overrun_q, overrun_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         sum_q     <= '0;
         count_q   <= '0;
         timer_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sum_q     <= sum_d;
         count_q   <= count_d;
         timer_q   <= timer_d;
         overrun_q <= overrun_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      sum_d     = sum_q;
      count_d   = count_q;
      timer_d   = timer_q;
      overrun_d = overrun_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.i_valid) begin
               sum_d   = sum_q + 32'(bus.i_data);
               count_d = CW'(1);
               timer_d = '0;
               state_d = (MESSAGE_LEN == 1) ? ST_DONE : ST_RECV;
            end
         end

         ST_RECV: begin
            // A byte on the expiry cycle wins over the timeout.
            if (bus.i_valid) begin
               sum_d   = sum_q + 32'(bus.i_data);
               count_d = count_q + CW'(1);
               timer_d = '0;
               if (count_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end
            end else if (timer_q == TIMER_END) begin
               state_d = ST_ERROR;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end

         ST_DONE, ST_ERROR: begin
            // Bytes are dropped while a result is pending; one that lands
            // together with the ack belongs to neither message.
            if (bus.i_ack) begin
               state_d   = ST_IDLE;
               sum_d     = '0;
               count_d   = '0;
               timer_d   = '0;
               overrun_d = 1'b0;
            end else if (bus.i_valid) begin
               overrun_d = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.o_sum     = sum_q;
   assign bus.o_count   = count_q;
   assign bus.o_busy    = (state_q == ST_RECV);
   assign bus.o_done    = (state_q == ST_DONE);
   assign bus.o_error   = (state_q == ST_ERROR);
   assign bus.o_overrun = overrun_q;

endmodule

// File: tb/tb_uart_sink.sv
module tb_uart_sink;

   typedef struct packed {
      logic [31:0] sum;
      logic [31:0] cnt;
      logic        busy;
      logic        done;
      logic        err;
      logic        ovr;
   } exp_t;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       a;
      exp_t       e;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] drv_data  = 8'h00;
   logic       drv_valid = 1'b0;
   logic       drv_ack   = 1'b0;
   logic [2:0] sel = 3'd0;

   int n_chk  = 0;
   int n_pass = 0;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   // 0: LEN4/T8  1: LEN2/T8  2: LEN8/T8  3: LEN512/default  4: LEN1/T8
   uart_sink_if #(.MESSAGE_LEN(4))   if4 ();
   uart_sink_if #(.MESSAGE_LEN(2))   if2 ();
   uart_sink_if #(.MESSAGE_LEN(8))   if8 ();
   uart_sink_if #(.MESSAGE_LEN(512)) if512 ();
   uart_sink_if #(.MESSAGE_LEN(1))   if1 ();

   uart_sink #(.MESSAGE_LEN(4),   .TIMEOUT(8)) dut4   (.clk(clk), .rst(rst), .bus(if4));
   uart_sink #(.MESSAGE_LEN(2),   .TIMEOUT(8)) dut2   (.clk(clk), .rst(rst), .bus(if2));
   uart_sink #(.MESSAGE_LEN(8),   .TIMEOUT(8)) dut8   (.clk(clk), .rst(rst), .bus(if8));
   uart_sink #(.MESSAGE_LEN(512))              dut512 (.clk(clk), .rst(rst), .bus(if512));
   uart_sink #(.MESSAGE_LEN(1),   .TIMEOUT(8)) dut1   (.clk(clk), .rst(rst), .bus(if1));

   assign if4.i_data = drv_data;   assign if4.i_valid = drv_valid;   assign if4.i_ack = drv_ack;
   assign if2.i_data = drv_data;   assign if2.i_valid = drv_valid;   assign if2.i_ack = drv_ack;
   assign if8.i_data = drv_data;   assign if8.i_valid = drv_valid;   assign if8.i_ack = drv_ack;
   assign if512.i_data = drv_data; assign if512.i_valid = drv_valid; assign if512.i_ack = drv_ack;
   assign if1.i_data = drv_data;   assign if1.i_valid = drv_valid;   assign if1.i_ack = drv_ack;

   logic [67:0] obs [5];
   assign obs[0] = {if4.o_sum,   32'(if4.o_count),   if4.o_busy,   if4.o_done,   if4.o_error,   if4.o_overrun};
   assign obs[1] = {if2.o_sum,   32'(if2.o_count),   if2.o_busy,   if2.o_done,   if2.o_error,   if2.o_overrun};
   assign obs[2] = {if8.o_sum,   32'(if8.o_count),   if8.o_busy,   if8.o_done,   if8.o_error,   if8.o_overrun};
   assign obs[3] = {if512.o_sum, 32'(if512.o_count), if512.o_busy, if512.o_done, if512.o_error, if512.o_overrun};
   assign obs[4] = {if1.o_sum,   32'(if1.o_count),   if1.o_busy,   if1.o_done,   if1.o_error,   if1.o_overrun};

   exp_t mon;
   always_comb begin
      mon = '0;
      if (sel < 3'd5) mon = obs[sel];
   end

   function automatic exp_t mk(input logic [31:0] s, input int c,
                               input logic b, input logic dn,
                               input logic er, input logic ov);
      exp_t e;
      e.sum  = s;
      e.cnt  = c;
      e.busy = b;
      e.done = dn;
      e.err  = er;
      e.ovr  = ov;
      return e;
   endfunction

   function automatic vec_t mv(input logic v, input logic [7:0] d, input logic a, input exp_t e);
      vec_t r;
      r.v = v;
      r.d = d;
      r.a = a;
      r.e = e;
      return r;
   endfunction

   task automatic check(input string name);
      exp_t e;
      if (sb_q.size() == 0) begin
         n_chk++;
         $display("FAIL %s: scoreboard empty, got sum=%h cnt=%0d", name, mon.sum, mon.cnt);
         return;
      end
      e = sb_q.pop_front();
      n_chk++;
      if (mon === e) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got sum=%h cnt=%0d busy=%b done=%b err=%b ovr=%b, expected sum=%h cnt=%0d busy=%b done=%b err=%b ovr=%b",
                  name, mon.sum, mon.cnt, mon.busy, mon.done, mon.err, mon.ovr,
                  e.sum, e.cnt, e.busy, e.done, e.err, e.ovr);
      end
   endtask

   // Drive one cycle of stimulus, expect the state visible after the edge.
   task automatic cycle(input logic v, input logic [7:0] d, input logic a,
                        input exp_t e, input string name);
      drv_valid = v;
      drv_data  = v ? d : 8'($urandom);
      drv_ack   = a;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      drv_valid = 1'b0;
      drv_ack   = 1'b0;
      drv_data  = 8'($urandom);
      check(name);
   endtask

   task automatic do_reset(input string name);
      rst = 1'b1;
      sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
      #2;
      check({name, "_async"});
      drv_valid = 1'b1;
      drv_data  = 8'h5A;
      sb_q.push_back(mk(0, 0, 0, 0, 0, 0));
      @(posedge clk);
      #1;
      drv_valid = 1'b0;
      check({name, "_held"});
      rst = 1'b0;
      cycle(0, 8'h00, 0, mk(0, 0, 0, 0, 0, 0), {name, "_release"});
   endtask

   vec_t tbl[$];

   initial begin
      #1;

      // Table: LEN4 message with 3-cycle spacing, overrun, ack handling.
      sel = 3'd0;
      do_reset("s1_rst");
      tbl.push_back(mv(1, 8'h10, 0, mk(32'h10, 1, 1, 0, 0, 0)));
      tbl.push_back(mv(0, 8'h00, 1, mk(32'h10, 1, 1, 0, 0, 0)));
      tbl.push_back(mv(0, 8'h00, 0, mk(32'h10, 1, 1, 0, 0, 0)));
      tbl.push_back(mv(1, 8'h20, 0, mk(32'h30, 2, 1, 0, 0, 0)));
      tbl.push_back(mv(0, 8'h00, 0, mk(32'h30, 2, 1, 0, 0, 0)));
      tbl.push_back(mv(0, 8'h00, 0, mk(32'h30, 2, 1, 0, 0, 0)));
      tbl.push_back(mv(1, 8'h30, 0, mk(32'h60, 3, 1, 0, 0, 0)));
      tbl.push_back(mv(0, 8'h00, 0, mk(32'h60, 3, 1, 0, 0, 0)));
      tbl.push_back(mv(0, 8'h00, 0, mk(32'h60, 3, 1, 0, 0, 0)));
      tbl.push_back(mv(1, 8'h40, 0, mk(32'hA0, 4, 0, 1, 0, 0)));
      tbl.push_back(mv(0, 8'h00, 0, mk(32'hA0, 4, 0, 1, 0, 0)));
      tbl.push_back(mv(1, 8'h77, 0, mk(32'hA0, 4, 0, 1, 0, 1)));
      tbl.push_back(mv(0, 8'h00, 0, mk(32'hA0, 4, 0, 1, 0, 1)));
      tbl.push_back(mv(0, 8'h00, 1, mk(0, 0, 0, 0, 0, 0)));
      tbl.push_back(mv(0, 8'h00, 1, mk(0, 0, 0, 0, 0, 0)));
      tbl.push_back(mv(0, 8'h00, 0, mk(0, 0, 0, 0, 0, 0)));
      for (int i = 0; i < tbl.size(); i++) begin
         cycle(tbl[i].v, tbl[i].d, tbl[i].a, tbl[i].e, $sformatf("s1_row%0d", i));
      end

      // Timeout: error exactly 8 cycles after the last byte.
      do_reset("s2_rst");
      cycle(1, 8'h01, 0, mk(1, 1, 1, 0, 0, 0), "s2_b1");
      cycle(1, 8'h02, 0, mk(3, 2, 1, 0, 0, 0), "s2_b2");
      for (int i = 1; i < 8; i++) cycle(0, 8'h00, 0, mk(3, 2, 1, 0, 0, 0), $sformatf("s2_wait%0d", i));
      cycle(0, 8'h00, 0, mk(3, 2, 0, 0, 1, 0), "s2_error");
      cycle(1, 8'hEE, 0, mk(3, 2, 0, 0, 1, 1), "s2_err_overrun");
      cycle(0, 8'h00, 1, mk(0, 0, 0, 0, 0, 0), "s2_ack");

      // Byte on the expiry cycle is accepted and restarts the timer.
      do_reset("s3_rst");
      cycle(1, 8'h01, 0, mk(1, 1, 1, 0, 0, 0), "s3_b1");
      for (int i = 1; i < 8; i++) cycle(0, 8'h00, 0, mk(1, 1, 1, 0, 0, 0), $sformatf("s3_wait%0d", i));
      cycle(1, 8'h05, 0, mk(6, 2, 1, 0, 0, 0), "s3_limit_byte");
      for (int i = 1; i < 8; i++) cycle(0, 8'h00, 0, mk(6, 2, 1, 0, 0, 0), $sformatf("s3_rewait%0d", i));
      cycle(0, 8'h00, 0, mk(6, 2, 0, 0, 1, 0), "s3_error");
      cycle(0, 8'h00, 1, mk(0, 0, 0, 0, 0, 0), "s3_ack");

      // LEN2: overrun while done, then ack with coincident byte.
      sel = 3'd1;
      do_reset("s4_rst");
      cycle(1, 8'hFF, 0, mk(32'hFF, 1, 1, 0, 0, 0), "s4_b1");
      cycle(1, 8'hFF, 0, mk(32'h1FE, 2, 0, 1, 0, 0), "s4_b2");
      cycle(1, 8'h55, 0, mk(32'h1FE, 2, 0, 1, 0, 1), "s4_overrun");
      cycle(1, 8'h55, 1, mk(0, 0, 0, 0, 0, 0), "s4_ack_valid");
      cycle(0, 8'h00, 0, mk(0, 0, 0, 0, 0, 0), "s4_idle");

      // LEN512: back-to-back full messages.
      sel = 3'd3;
      do_reset("s5_rst");
      for (int k = 1; k <= 512; k++)
         cycle(1, 8'hFF, 0, mk(32'(255 * k), k, k < 512, k == 512, 0, 0), $sformatf("s5_ff%0d", k));
      cycle(0, 8'h00, 1, mk(0, 0, 0, 0, 0, 0), "s5_ack1");
      for (int k = 1; k <= 512; k++)
         cycle(1, 8'h00, 0, mk(0, k, k < 512, k == 512, 0, 0), $sformatf("s5_zero%0d", k));
      cycle(1, 8'h12, 0, mk(0, 512, 0, 1, 0, 1), "s5_count_cap");
      cycle(0, 8'h00, 1, mk(0, 0, 0, 0, 0, 0), "s5_ack2");

      // LEN8: reset mid-message discards the partial result.
      sel = 3'd2;
      do_reset("s6_rst");
      for (int k = 1; k <= 5; k++) cycle(1, 8'h01, 0, mk(k, k, 1, 0, 0, 0), $sformatf("s6_pre%0d", k));
      do_reset("s6_midrst");
      for (int k = 1; k <= 8; k++) cycle(1, 8'h01, 0, mk(k, k, k < 8, k == 8, 0, 0), $sformatf("s6_msg%0d", k));

      // LEN1: a single byte completes the message directly from idle.
      sel = 3'd4;
      do_reset("s7_rst");
      cycle(1, 8'h9A, 0, mk(32'h9A, 1, 0, 1, 0, 0), "s7_single");
      cycle(0, 8'h00, 1, mk(0, 0, 0, 0, 0, 0), "s7_ack");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
